// File: rtl/riscv_dmem_arbiter_pkg.sv
// Shared types and encodings for the data-memory arbiter: FSM states,
// master ids and the store-size encoding driven to the IO bridge.
package riscv_dmem_arbiter_pkg;

  localparam int CACHE_D_WRITE_LEN = 2;

  localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SW = 2'd0;
  localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SH = 2'd1;
  localparam logic [CACHE_D_WRITE_LEN-1:0] CACHE_D_WRITE_SB = 2'd2;

  typedef enum logic [1:0] {
    DMEM_ARB_IDLE = 2'd0,
    DMEM_ARB_WAIT = 2'd1,
    DMEM_ARB_RESP = 2'd2
  } dmem_arb_state_e;

  localparam logic DMEM_ARB_M0 = 1'b0;
  localparam logic DMEM_ARB_M1 = 1'b1;

endpackage

// File: rtl/riscv_dmem_arbiter_rr_picker.sv
// Two-way combinational picker: round-robin on ties unless fixed priority
// is selected, in which case requester 0 always wins a tie.
module riscv_rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      // last=1 means requester 1 was served most recently, so 0 goes next
      gnt = (fixed || last) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/riscv_dmem_arbiter.sv
// Two-master arbiter for the single data-memory/IO bridge port: grants one
// access at a time, holds read addresses for RD_LATENCY cycles, pulses rvalid.
module riscv_dmem_arbiter
  import riscv_dmem_arbiter_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m0_req,
  input  logic                         m0_we,
  input  logic [CACHE_D_WRITE_LEN-1:0] m0_wtype,
  input  logic [31:0]                  m0_addr,
  input  logic [31:0]                  m0_wdata,
  output logic                         m0_gnt,
  output logic                         m0_rvalid,
  output logic [31:0]                  m0_rdata,
  input  logic                         m1_req,
  input  logic                         m1_we,
  input  logic [CACHE_D_WRITE_LEN-1:0] m1_wtype,
  input  logic [31:0]                  m1_addr,
  input  logic [31:0]                  m1_wdata,
  output logic                         m1_gnt,
  output logic                         m1_rvalid,
  output logic [31:0]                  m1_rdata,
  output logic                         bus_write_en,
  output logic [CACHE_D_WRITE_LEN-1:0] bus_write,
  output logic [31:0]                  bus_addr,
  output logic [31:0]                  bus_wdata,
  input  logic [31:0]                  bus_rdata,
  output logic                         busy,
  output logic [1:0]                   dbg_state
);

  // Handshake: a master holds req and stable fields until it sees gnt=1 in a
  // cycle; the access is accepted at that edge. Read data returns later as a
  // single-cycle rvalid pulse to the master that owned the read.

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  dmem_arb_state_e state_q;
  logic            last_q;
  logic            owner_q;
  logic [1:0]      rd_cnt_q;
  logic [31:0]     addr_q;
  logic [1:0]      rvalid_q;
  logic [31:0]     rdata0_q, rdata1_q;

  logic [1:0] req_gated, gnt;
  logic       win, win_we;

  assign req_gated = {m1_req, m0_req} & {2{rst && (state_q == DMEM_ARB_IDLE)}};

  riscv_rr_picker u_picker (
    .req   (req_gated),
    .last  (last_q),
    .fixed (FIXED_PRIO),
    .gnt   (gnt)
  );

  assign win    = gnt[1];
  assign win_we = win ? m1_we : m0_we;

  assign m0_gnt       = gnt[0];
  assign m1_gnt       = gnt[1];
  assign bus_write_en = (|gnt) && win_we;
  assign bus_write    = win ? m1_wtype : m0_wtype;
  assign bus_wdata    = win ? m1_wdata : m0_wdata;
  assign bus_addr     = (state_q != DMEM_ARB_IDLE) ? addr_q :
                        (win ? m1_addr : m0_addr);

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign busy      = (state_q != DMEM_ARB_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= DMEM_ARB_IDLE;
      last_q   <= DMEM_ARB_M1;
      owner_q  <= DMEM_ARB_M0;
      rd_cnt_q <= 2'd0;
      addr_q   <= 32'd0;
      rvalid_q <= 2'b00;
      rdata0_q <= 32'd0;
      rdata1_q <= 32'd0;
    end else begin
      case (state_q)
        DMEM_ARB_IDLE: begin
          if (|gnt) begin
            last_q <= win;
            if (!win_we) begin
              addr_q   <= bus_addr;
              owner_q  <= win;
              rd_cnt_q <= 2'd1;
              state_q  <= DMEM_ARB_WAIT;
            end
          end
        end
        DMEM_ARB_WAIT: begin
          rd_cnt_q <= rd_cnt_q + 2'd1;
          if (rd_cnt_q == LAT) begin
            if (owner_q == DMEM_ARB_M1) begin
              rdata1_q    <= bus_rdata;
              rvalid_q[1] <= 1'b1;
            end else begin
              rdata0_q    <= bus_rdata;
              rvalid_q[0] <= 1'b1;
            end
            state_q <= DMEM_ARB_RESP;
          end
        end
        DMEM_ARB_RESP: begin
          rvalid_q <= 2'b00;
          state_q  <= DMEM_ARB_IDLE;
        end
        default: state_q <= DMEM_ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter: round-robin instance (RD_LATENCY=1)
// plus a fixed-priority instance sharing the same stimulus.
module tb_riscv_dmem_arbiter;
  import riscv_dmem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_wtype, m1_wtype;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, bus_write_en, busy;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;
  logic [1:0]  bus_write, dbg_state;

  logic        f_m0_gnt, f_m0_rvalid, f_m1_gnt, f_m1_rvalid, f_bus_write_en, f_busy;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_bus_addr, f_bus_wdata;
  logic [1:0]  f_bus_write, f_dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  riscv_dmem_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wtype(m0_wtype), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wtype(m1_wtype), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .bus_write_en(bus_write_en), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  riscv_dmem_arbiter #(.RD_LATENCY(1), .FIXED_PRIO(1'b1)) u_fix (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_wtype(m0_wtype), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(f_m0_gnt), .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_wtype(m1_wtype), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(f_m1_gnt), .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata),
    .bus_write_en(f_bus_write_en), .bus_write(f_bus_write), .bus_addr(f_bus_addr),
    .bus_wdata(f_bus_wdata), .bus_rdata(bus_rdata), .busy(f_busy), .dbg_state(f_dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_drive();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_wtype = CACHE_D_WRITE_SW;
    m0_addr = 32'h0000_0100; m0_wdata = 32'h1111_1111;
    m1_req = 1'b1; m1_we = 1'b1; m1_wtype = CACHE_D_WRITE_SB;
    m1_addr = 32'h0000_0200; m1_wdata = 32'h2222_2222;
    bus_rdata = 32'h0;

    // reset with both masters requesting
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_wen", bus_write_en, 0);
    check("rst_busy", busy, 0);
    check("rst_f_m0_gnt", f_m0_gnt, 0);

    // continuous writes from both: alternate vs fixed priority
    next_drive(); rst = 1'b1;
    @(negedge clk);
    check("rr0_m0_gnt", m0_gnt, 1);
    check("rr0_m1_gnt", m1_gnt, 0);
    check("rr0_wen", bus_write_en, 1);
    check("rr0_addr", bus_addr, 32'h0000_0100);
    check("fx0_m0_gnt", f_m0_gnt, 1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      check("rr_m1_gnt", m1_gnt, (i % 2 == 1));
      check("rr_m0_gnt", m0_gnt, (i % 2 == 0));
      check("rr_wtype", bus_write, (i % 2 == 1) ? CACHE_D_WRITE_SB : CACHE_D_WRITE_SW);
      check("fx_m0_gnt", f_m0_gnt, 1);
      check("fx_m1_gnt", f_m1_gnt, 0);
    end

    // m0 SW to IO space
    next_drive();
    m1_req = 1'b0;
    m0_addr = 32'hFFFF_FC04; m0_wdata = 32'h00A5_A5A5; m0_wtype = CACHE_D_WRITE_SW;
    @(negedge clk);
    check("sw_gnt", m0_gnt, 1);
    check("sw_wen", bus_write_en, 1);
    check("sw_addr", bus_addr, 32'hFFFF_FC04);
    check("sw_wdata", bus_wdata, 32'h00A5_A5A5);
    check("sw_wtype", bus_write, CACHE_D_WRITE_SW);
    next_drive(); m0_req = 1'b0;
    @(negedge clk);
    check("sw_wen_off", bus_write_en, 0);
    check("sw_rvalid", m0_rvalid, 0);
    check("sw_busy", busy, 0);

    // m1 load, then m0 write request arrives while the read is in flight
    next_drive();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0010;
    bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("ld_m1_gnt", m1_gnt, 1);
    check("ld_m0_gnt", m0_gnt, 0);
    check("ld_wen", bus_write_en, 0);
    check("ld_addr", bus_addr, 32'h0000_0010);
    next_drive();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0020; m0_wdata = 32'h0000_0055;
    @(negedge clk);
    check("wait_busy", busy, 1);
    check("wait_m0_gnt", m0_gnt, 0);
    check("wait_addr", bus_addr, 32'h0000_0010);
    check("wait_m1_rvalid", m1_rvalid, 0);
    check("wait_wen", bus_write_en, 0);
    @(negedge clk);
    check("resp_m1_rvalid", m1_rvalid, 1);
    check("resp_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
    check("resp_m0_rvalid", m0_rvalid, 0);
    check("resp_m0_gnt", m0_gnt, 0);
    check("resp_m0_rdata", m0_rdata, 32'h0);
    @(negedge clk);
    check("idle_m0_gnt", m0_gnt, 1);
    check("idle_addr", bus_addr, 32'h0000_0020);
    check("idle_wen", bus_write_en, 1);
    check("idle_m1_rvalid", m1_rvalid, 0);

    // m0 read aborted by reset during WAIT
    next_drive();
    m0_we = 1'b0; m0_addr = 32'h0000_0040; bus_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("ab_gnt", m0_gnt, 1);
    next_drive(); m0_req = 1'b0; rst = 1'b0;
    @(negedge clk);
    check("ab_rst_gnt", m0_gnt, 0);
    check("ab_rst_rvalid", m0_rvalid, 0);
    next_drive();
    rst = 1'b1;
    m0_req = 1'b1; m0_addr = 32'h0000_0044; bus_rdata = 32'h1234_5678;
    @(negedge clk);
    check("ab_busy", busy, 0);
    check("ab_rvalid", m0_rvalid, 0);
    check("ab_dbg_state", dbg_state, DMEM_ARB_IDLE);
    check("re_gnt", m0_gnt, 1);
    next_drive(); m0_req = 1'b0;
    @(negedge clk);
    check("re_busy", busy, 1);
    check("re_addr", bus_addr, 32'h0000_0044);
    check("re_rvalid_early", m0_rvalid, 0);
    @(negedge clk);
    check("re_rvalid", m0_rvalid, 1);
    check("re_rdata", m0_rdata, 32'h1234_5678);
    check("re_m1_rvalid", m1_rvalid, 0);
    check("re_m1_rdata", m1_rdata, 32'h0);
    @(negedge clk);
    check("re_rvalid_clr", m0_rvalid, 0);
    check("re_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_arbiter.md
Name: riscv_dmem_arbiter

Overview:
- Two-master arbiter and sequencer for the single data-memory/IO bridge port.
  - Master 0 is the CPU MEM stage; master 1 is a secondary requester such as a debug or DMA engine.
- Grants one access at a time, using round-robin or fixed priority.
- Holds the address stable for the bridge's synchronous read latency, then returns read data to the granted master with a one-cycle valid pulse.
- Sits between the pipeline/debug logic and the IO bridge; the bridge sees one plain master.

Parameters:
- RD_LATENCY, 1: cycles from address presentation to valid bus_rdata (range 1..3).
- FIXED_PRIO, 0: 0 means round-robin; 1 means master 0 always wins ties.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk)
- m0_req  in  1  master 0 access request; held until m0_gnt
- m0_we  in  1  1 = store, 0 = load
- m0_wtype  in  CACHE_D_WRITE_LEN  store size (SW/SH/SB encoding)
- m0_addr  in  32  byte address
- m0_wdata  in  32  store data
- m0_gnt  out  1  request accepted this cycle
- m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
- m0_rdata  out  32  load data
- m1_req, m1_we, m1_wtype, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for master 1
- bus_write_en  out  1  to bridge cache_d_write_en
- bus_write  out  CACHE_D_WRITE_LEN  to bridge cache_d_write
- bus_addr  out  32  to bridge addr
- bus_wdata  out  32  to bridge data_to_cache
- bus_rdata  in  32  from bridge data_out
- busy  out  1  read in flight (state != IDLE)

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, last_gnt=1 (so m0 wins the first tie), rd_cnt=0, rvalid regs=0, rdata regs=0.
  - m*_gnt and bus_write_en are forced to 0 while rst=0.
  - Reset mid-read aborts the access: no rvalid is ever produced for it.
- States: IDLE, WAIT, RESP.
- IDLE, arbitration (combinational):
  - Only one requester: it wins.
  - Both request: FIXED_PRIO=1 gives m0; otherwise the master != last_gnt wins.
  - Winner's gnt=1 in the same cycle. bus_addr, bus_write and bus_wdata mux from the winner combinationally.
  - last_gnt updates at the edge of every grant.
- Write grant (we=1):
  - bus_write_en=1 for that cycle only, with bus_write = winner's wtype.
  - Write is committed at the edge; state stays IDLE. No rvalid for writes.
  - Back-to-back writes are possible every cycle.
- Read grant (we=0):
  - bus_write_en=0. At the edge: latch addr and master id, rd_cnt=1, go to WAIT.
- WAIT:
  - bus_addr = latched addr; bus_write_en=0; no gnt to anyone.
  - rd_cnt increments each edge.
  - At the edge where rd_cnt==RD_LATENCY: capture bus_rdata into the owner's rdata register, set the owner's rvalid, go to RESP.
- RESP:
  - Owner's rvalid=1 for exactly this cycle; no grant issued.
  - Next state IDLE; rvalid clears at that edge.
- Read timing with RD_LATENCY=L: gnt in cycle T, rvalid in cycle T+L+1. The next grant is possible at T+L+2.
- The non-owner's rdata register keeps its old value; its rvalid stays 0.
- A requester may drop req before gnt; nothing happens. Request fields must be stable while req=1 and gnt=0.
- Simultaneous arrival of the second request during WAIT/RESP: it is held and arbitrated on return to IDLE, with round-robin preventing starvation.
- Address decoding (IO vs cache) is left to the bridge; the arbiter is address-agnostic.

Decomposition:
- riscv_defs.v gains:
  - DMEM_ARB_IDLE/WAIT/RESP state encodings (2 bits).
  - DMEM_ARB_M0/M1 master ids.
- Reuse the existing CACHE_D_WRITE_* defines.
- Sub-module riscv_rr_picker: 2-way picker.
  - Inputs: req[1:0], last, fixed.
  - Output: one-hot gnt.
  - Purely combinational; reusable for future ports.

Test Plan:
- Reset with both req=1 and rst=0 -> both gnt=0, bus_write_en=0, busy=0. First cycle after rst=1 -> m0_gnt=1.
- m0 SW: addr=0xFFFFFC04, wdata=0x00A5A5A5 -> m0_gnt=1 and bus_write_en=1 for 1 cycle, bus_addr=0xFFFFFC04. m0_rvalid is never asserted.
- m1 load, addr=0x00000010, bridge returns 0xDEADBEEF, RD_LATENCY=1 -> m1_gnt at T, bus_addr held at T+1, m1_rvalid=1 with m1_rdata=0xDEADBEEF at T+2, m0_rvalid=0 throughout.
- m0 and m1 issue continuous writes, FIXED_PRIO=0 -> grants alternate m0,m1,m0,m1 one per cycle. With FIXED_PRIO=1 -> m0 every cycle and m1 never granted.
- m0 read in flight while m1 requests -> m1_gnt=0 through WAIT/RESP. m1_gnt=1 in the first IDLE cycle (T+L+2).
- rst=0 pulsed during WAIT -> state IDLE, no m*_rvalid. A following read completes normally with correct data.
